// File: rtl/operand_fetch_stage.sv
// Decode/operand fetch into ID/EX: R15 resolves to PC+8, EX/MEM forwarding, load-use bubble.
// One cycle latency. A low ex_ready holds ID/EX and deasserts if_ready. Flush always consumes and drops.
module operand_fetch_stage (
    input  logic        clk,
    input  logic        Reset,
    input  logic        if_valid,
    input  logic [31:0] if_ir,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    input  logic [31:0] rf_a,
    input  logic [31:0] rf_b,
    input  logic        ex_wr_en,
    input  logic        ex_is_load,
    input  logic [3:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        mem_wr_en,
    input  logic [3:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc,
    output logic [31:0] id_opa,
    output logic [31:0] id_opb,
    output logic [3:0]  id_rd,
    output logic        id_wr_en,
    output logic        id_is_load,
    output logic [15:0] stall_cnt
);

    logic [1:0]  w_class;
    logic [3:0]  w_op;
    logic        w_use_a;
    logic        w_use_b;
    logic        w_wr_en;
    logic        w_is_load;
    logic        w_ex_fwd;
    logic        w_hazard;
    logic [31:0] w_pc8;
    logic [31:0] w_opa;
    logic [31:0] w_opb;

    logic        r_id_valid;
    logic [31:0] r_id_ir;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_opa;
    logic [31:0] r_id_opb;
    logic [3:0]  r_id_rd;
    logic        r_id_wr_en;
    logic        r_id_is_load;
    logic [15:0] r_stall_cnt;

    // A load in EX has no data yet, so only non-load EX results are forwardable.
    function automatic logic [31:0] resolve(
        input logic [3:0]  idx,
        input logic [31:0] rf_dat,
        input logic [31:0] pc8,
        input logic        ex_fwd,
        input logic [3:0]  ex_dst,
        input logic [31:0] ex_dat,
        input logic        mem_fwd,
        input logic [3:0]  mem_dst,
        input logic [31:0] mem_dat
    );
        if (idx == 4'd15)
            return pc8;
        else if (ex_fwd && ex_dst == idx)
            return ex_dat;
        else if (mem_fwd && mem_dst == idx)
            return mem_dat;
        else
            return rf_dat;
    endfunction

    assign w_class   = if_ir[27:26];
    assign w_op      = if_ir[24:21];
    assign ra        = if_ir[19:16];
    assign rb        = if_ir[3:0];
    assign w_use_a   = (w_class != 2'b10);
    assign w_use_b   = ((w_class == 2'b00) && !if_ir[25]) || ((w_class == 2'b01) && if_ir[25]);
    assign w_wr_en   = ((w_class == 2'b00) && ((w_op < 4'b1000) || (w_op > 4'b1011)))
                     || ((w_class == 2'b01) && if_ir[20]);
    assign w_is_load = (w_class == 2'b01) && if_ir[20];
    assign w_pc8     = if_pc + 32'd8;
    assign w_ex_fwd  = ex_wr_en && !ex_is_load;

    assign w_opa = resolve(ra, rf_a, w_pc8, w_ex_fwd, ex_rd, ex_result, mem_wr_en, mem_rd, mem_result);
    assign w_opb = resolve(rb, rf_b, w_pc8, w_ex_fwd, ex_rd, ex_result, mem_wr_en, mem_rd, mem_result);

    assign w_hazard = if_valid && ex_wr_en && ex_is_load
                    && ((w_use_a && (ex_rd == ra) && (ra != 4'd15))
                     || (w_use_b && (ex_rd == rb) && (rb != 4'd15)));

    assign if_ready = flush || (ex_ready && !w_hazard);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_id_valid   <= 1'b0;
            r_id_ir      <= 32'd0;
            r_id_pc      <= 32'd0;
            r_id_opa     <= 32'd0;
            r_id_opb     <= 32'd0;
            r_id_rd      <= 4'd0;
            r_id_wr_en   <= 1'b0;
            r_id_is_load <= 1'b0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
        end else if (ex_ready) begin
            if (w_hazard) begin
                r_id_valid <= 1'b0;
            end else begin
                r_id_valid   <= if_valid;
                r_id_ir      <= if_ir;
                r_id_pc      <= if_pc;
                r_id_opa     <= w_opa;
                r_id_opb     <= w_opb;
                r_id_rd      <= if_ir[15:12];
                r_id_wr_en   <= w_wr_en;
                r_id_is_load <= w_is_load;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            r_stall_cnt <= 16'd0;
        else if (w_hazard && ex_ready && !flush && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign id_valid   = r_id_valid;
    assign id_ir      = r_id_ir;
    assign id_pc      = r_id_pc;
    assign id_opa     = r_id_opa;
    assign id_opb     = r_id_opb;
    assign id_rd      = r_id_rd;
    assign id_wr_en   = r_id_wr_en;
    assign id_is_load = r_id_is_load;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode/operand-fetch stage that sits directly upstream of the register file read ports and feeds the ID/EX pipeline register. It drives the two register-file read addresses from the fetched instruction and resolves R15 reads to PC+8. It selects forwarded results from EX and MEM over stale register-file data and inserts a one-cycle bubble on load-use hazards. It registers the decoded operands for the execute stage under a valid/ready handshake with flush.

## Interface
Parameters:
- none (data width fixed at 32, register index fixed at 4)

Ports (clk, Reset first; one clock; Reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state
- if_valid  in  1  fetch presents an instruction
- if_ir  in  32  instruction word
- if_pc  in  32  address of if_ir
- if_ready  out  1  stage accepts if_ir this cycle
- ra  out  4  register-file read address A = if_ir[19:16] (Rn), combinational
- rb  out  4  register-file read address B = if_ir[3:0] (Rm), combinational
- rf_a, rf_b  in  32  register-file read data for ra/rb (asynchronous read, same cycle)
- ex_wr_en, ex_is_load  in  1  EX-stage instruction writes a register / is a load
- ex_rd  in  4  EX-stage destination
- ex_result  in  32  EX-stage ALU result
- mem_wr_en  in  1  MEM-stage instruction writes a register
- mem_rd  in  4  MEM-stage destination
- mem_result  in  32  MEM-stage write-back value (ALU or load data)
- flush  in  1  taken branch / PC redirect; kill the instruction entering ID/EX
- ex_ready  in  1  execute stage can accept
- id_valid  out  1  ID/EX holds a real instruction
- id_ir, id_pc  out  32  registered instruction and its PC
- id_opa, id_opb  out  32  registered resolved operands
- id_rd  out  4  registered destination = if_ir[15:12]
- id_wr_en, id_is_load  out  1  registered write-enable / load flag
- stall_cnt  out  16  saturating count of load-use bubble cycles

## Operation
- Class = if_ir[27:26]; op = if_ir[24:21].
- use_a = class != 2'b10.
- use_b = (class==00 & !if_ir[25]) | (class==01 & if_ir[25]).
- wr_en = (class==00 & op not in 1000..1011) | (class==01 & if_ir[20]).
- is_load = class==01 & if_ir[20].
- Operand resolution for A (B is identical with rb/rf_b), highest priority first:
  - index 15 -> if_pc + 32'd8 (wraps mod 2^32; never forwarded);
  - ex_wr_en & ex_rd==index & !ex_is_load -> ex_result;
  - mem_wr_en & mem_rd==index -> mem_result;
  - otherwise -> rf_a.
- hazard = if_valid & ex_wr_en & ex_is_load & ((use_a & ex_rd==ra & ra!=15) | (use_b & ex_rd==rb & rb!=15)).
- if_ready = flush | (ex_ready & !hazard).
- Register update on each clk edge, first match wins:
  - Reset -> all outputs 0.
  - flush -> id_valid<=0; other ID/EX fields may take any value; the incoming instruction is consumed and dropped.
  - !ex_ready -> all ID/EX fields hold. EX and MEM also hold, so held operands stay valid.
  - hazard -> id_valid<=0 (bubble); the instruction stays presented and re-resolves next cycle, taking the load value from the MEM path.
  - else -> id_* <= resolved values; id_valid<=if_valid.
- stall_cnt increments when hazard & ex_ready & !flush, and saturates at 16'hFFFF.

## Timing
- Latency: one cycle from if_ir acceptance to id_* valid.
- ra, rb, if_ready: combinational from current inputs; no registered path.
- Reset (asynchronous, any cycle, including mid-stall): id_valid=0, id_ir=0, id_pc=0, id_opa=0, id_opb=0, id_rd=0, id_wr_en=0, id_is_load=0, stall_cnt=0 immediately. The first acceptance is possible on the first edge after deassertion.
- Load-use: exactly one bubble per dependent load, unless ex_ready is low, which extends it.
- flush + hazard in the same cycle: flush wins, no bubble counted, if_ready=1.
- flush + !ex_ready: flush wins; id_valid cleared.
- EX and MEM both match: the EX value is used.
- A writer to R15 is never forwarded; R15 always reads as if_pc+8.
- if_valid=0 with ex_ready=1 loads a bubble; no hazard is raised.

## Test plan
- Reset with garbage inputs, release, present ADD R1,R2,R3 (if_ir=0xE0821003, rf_a=5, rf_b=7) -> next edge: id_valid=1, id_opa=5, id_opb=7, id_rd=1, id_wr_en=1.
- R15 read: if_ir=0xE08F1003, if_pc=0x100 -> id_opa=0x108. if_pc=0xFFFFFFFC -> id_opa=0x4.
- Forward priority: ex_rd=mem_rd=2 with both writing, ex_result=0xAA, mem_result=0xBB, if_ir reads R2 -> id_opa=0xAA. Drop ex_wr_en -> 0xBB.
- Load-use: ex_is_load=1, ex_rd=3, ADD reading R3 -> one cycle with if_ready=0 and id_valid=0; stall_cnt 0->1. Next cycle (MEM forwards 0x55) -> id_opb=0x55, id_valid=1.
- Backpressure: ex_ready=0 for 3 cycles while fetch changes -> id_* unchanged; if_ready=0; stall_cnt unchanged.
- Flush during hazard -> id_valid=0, if_ready=1, stall_cnt unchanged. Assert Reset mid-hold -> all outputs 0 immediately.
